// File: rtl/phase_edge_detector_if.sv
// Sample-word and phase-measurement bundle of phase_edge_detector.
// master drives the oversampled words, slave returns the phase stream.
interface phase_edge_detector_if;
    logic       ena;
    logic [7:0] din;
    logic       update;
    logic [3:0] phase;
    logic       locked;
    logic [7:0] err_cnt;

    modport master (
        output ena,
        output din,
        input  update,
        input  phase,
        input  locked,
        input  err_cnt
    );

    modport slave (
        input  ena,
        input  din,
        output update,
        output phase,
        output locked,
        output err_cnt
    );
endinterface

// File: rtl/phase_edge_detector.sv
// Edge-phase detector for 8x-oversampled deser400 data, with lock FSM.
// Define PHDET_ERRCNT_EN to build the saturating err_cnt counter.
module phase_edge_detector #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int TOL      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    phase_edge_detector_if.slave bus
);

    typedef enum logic [1:0] {
        UNLOCK,
        ACQ,
        LOCK
    } state_t;

    localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_W = 4'(LOSS_CNT);
    localparam logic [3:0] TOL_W  = 4'(TOL);

    logic       prev_s7;
    logic [7:0] trans;
    logic [3:0] n_tr;
    logic [2:0] k_c;
    logic [3:0] pos_c;

    logic       s1_edge;
    logic       s1_multi;
    logic [3:0] s1_pos;

    state_t     state_q, state_d;
    logic [3:0] ref_q, ref_d;
    logic [3:0] good_q, good_d;
    logic [3:0] bad_q, bad_d;
    logic [3:0] phase_q, phase_d;
    logic       upd_q, upd_d;
    logic [3:0] diff;
    logic [3:0] dabs;
    logic       near;

    assign trans = bus.din ^ {bus.din[6:0], prev_s7};

    always_comb begin
        n_tr = '0;
        k_c  = '0;
        for (int i = 0; i < 8; i++) begin
            if (trans[i]) begin
                n_tr = n_tr + 4'd1;
                k_c  = 3'(i);
            end
        end
    end

    // edge between sample k-1 and k sits at half step 2k-1
    assign pos_c = {k_c, 1'b0} - 4'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_s7  <= 1'b0;
            s1_edge  <= 1'b0;
            s1_multi <= 1'b0;
            s1_pos   <= '0;
        end else if (bus.ena) begin
            prev_s7  <= bus.din[7];
            s1_edge  <= (n_tr == 4'd1);
            s1_multi <= (n_tr >= 4'd2);
            s1_pos   <= pos_c;
        end else begin
            s1_edge  <= 1'b0;
            s1_multi <= 1'b0;
        end
    end

    assign diff = s1_pos - ref_q;
    assign dabs = diff[3] ? (4'd0 - diff) : diff;
    assign near = (dabs <= TOL_W);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNLOCK;
            ref_q   <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            phase_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            phase_q <= phase_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        good_d  = good_q;
        bad_d   = bad_q;
        phase_d = phase_q;
        upd_d   = 1'b0;
        unique case (state_q)
            UNLOCK: begin
                if (s1_edge) begin
                    state_d = ACQ;
                    ref_d   = s1_pos;
                    good_d  = 4'd1;
                end
            end
            ACQ: begin
                if (s1_multi) begin
                    state_d = UNLOCK;
                    good_d  = '0;
                end else if (s1_edge) begin
                    ref_d = s1_pos;
                    if (!near) begin
                        good_d = 4'd1;
                    end else if (good_q + 4'd1 == LOCK_W) begin
                        state_d = LOCK;
                        good_d  = '0;
                        bad_d   = '0;
                        upd_d   = 1'b1;
                        phase_d = s1_pos;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
            end
            LOCK: begin
                if (s1_edge && near) begin
                    upd_d   = 1'b1;
                    phase_d = s1_pos;
                    ref_d   = s1_pos;
                    bad_d   = '0;
                end else if (s1_edge || s1_multi) begin
                    if (bad_q + 4'd1 == LOSS_W) begin
                        state_d = UNLOCK;
                        bad_d   = '0;
                        good_d  = '0;
                    end else begin
                        bad_d = bad_q + 4'd1;
                    end
                end
            end
            default: state_d = UNLOCK;
        endcase
    end

    assign bus.update = upd_q;
    assign bus.phase  = phase_q;
    assign bus.locked = (state_q == LOCK);

`ifdef PHDET_ERRCNT_EN
    logic [7:0] err_q;
    logic       err_ev;

    assign err_ev = s1_multi
                  | (s1_edge & ~near & (state_q != UNLOCK));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (err_ev && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_q;
`else
    assign bus.err_cnt = '0;
`endif

endmodule

// File: tb/tb_phase_edge_detector.sv
// Scoreboard bench for phase_edge_detector: directed word streams,
// expected updates queued by the driver and checked by a monitor.
module tb_phase_edge_detector;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    phase_edge_detector_if bus();

    phase_edge_detector #(
        .LOCK_CNT(8),
        .LOSS_CNT(4),
        .TOL     (2)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef PHDET_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] ph;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    function automatic logic [7:0] ex_err(int n);
        return ERR_EN ? 8'(n) : 8'd0;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // monitor: pops one expected entry per update strobe
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (bus.update === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_update: phase %0d at cycle %0d",
                             bus.phase, cyc);
                end else begin
                    e = sb.pop_front();
                    check("upd_phase", 32'(bus.phase), 32'(e.ph));
                    check("upd_cycle", cyc, e.at);
                    check("upd_locked", 32'(bus.locked), 32'd1);
                end
            end else if (sb.size() > 0 && sb[0].at <= cyc) begin
                e = sb.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missed_update: got none, expected phase %0d at cycle %0d",
                         e.ph, e.at);
            end
        end
    end

    task automatic send(logic [7:0] d, bit upd, logic [3:0] ph);
        exp_t e;
        bus.ena = 1'b1;
        bus.din = d;
        if (upd) begin
            e.ph = ph;
            e.at = cyc + 2;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            bus.ena = 1'b0;
            bus.din = 8'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.ena = 1'b0;
        bus.din = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_update", 32'(bus.update), 32'd0);
        check("rst_phase", 32'(bus.phase), 32'd0);
        check("rst_locked", 32'(bus.locked), 32'd0);
        check("rst_err", 32'(bus.err_cnt), 32'd0);
        reset_n = 1'b1;

        // constant data: no transitions at all
        repeat (20) send(8'h00, 1'b0, 4'd0);
        check("quiet_locked", 32'(bus.locked), 32'd0);
        check("quiet_phase", 32'(bus.phase), 32'd0);

        // edge at k=4 -> half step 7, lock on the 8th word
        for (int i = 0; i < 12; i++)
            send((i % 2) ? 8'h0F : 8'hF0, i >= 7, 4'd7);
        check("k4_locked", 32'(bus.locked), 32'd1);
        check("k4_err", 32'(bus.err_cnt), 32'(ex_err(0)));

        // stalled input must not disturb anything
        idle(5);
        check("stall_locked", 32'(bus.locked), 32'd1);
        check("stall_err", 32'(bus.err_cnt), 32'(ex_err(0)));
        for (int i = 0; i < 4; i++)
            send((i % 2) ? 8'h0F : 8'hF0, 1'b1, 4'd7);

        // three multi-transition words then a good one keeps lock
        repeat (3) send(8'h10, 1'b0, 4'd0);
        send(8'hF0, 1'b1, 4'd7);
        check("bad3_locked", 32'(bus.locked), 32'd1);
        // four in a row drops lock two cycles after the last
        repeat (4) send(8'h10, 1'b0, 4'd0);
        bus.ena = 1'b0;
        check("loss_lk_before", 32'(bus.locked), 32'd1);
        @(negedge clk);
        check("loss_lk_fall", 32'(bus.locked), 32'd0);
        check("loss_err", 32'(bus.err_cnt), 32'(ex_err(7)));
        check("loss_phase_hold", 32'(bus.phase), 32'd7);

        reset_n = 1'b0;
        #1;
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;

        // k=0 wraps to half step 15
        for (int i = 0; i < 10; i++)
            send((i % 2) ? 8'h00 : 8'hFF, i >= 7, 4'd15);
        // half step 1 is +2 across the wrap: accepted
        for (int i = 0; i < 4; i++)
            send((i % 2) ? 8'h01 : 8'hFE, 1'b1, 4'd1);
        check("wrap_err", 32'(bus.err_cnt), 32'(ex_err(0)));
        // half step 5 is +4: rejected
        send(8'hF8, 1'b0, 4'd0);
        send(8'h01, 1'b1, 4'd1);
        check("far_err", 32'(bus.err_cnt), 32'(ex_err(1)));
        check("far_locked", 32'(bus.locked), 32'd1);

        // asynchronous reset between clock edges while locked
        send(8'hFE, 1'b1, 4'd1);
        send(8'h01, 1'b1, 4'd1);
        bus.ena = 1'b0;
        check("pre_rst_update", 32'(bus.update), 32'd1);
        #2;
        reset_n = 1'b0;
        sb.delete();
        #1;
        check("arst_update", 32'(bus.update), 32'd0);
        check("arst_phase", 32'(bus.phase), 32'd0);
        check("arst_locked", 32'(bus.locked), 32'd0);
        check("arst_err", 32'(bus.err_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++)
            send((i % 2) ? 8'h01 : 8'hFE, i == 7, 4'd1);
        idle(4);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
